// File: rtl/elevator_request_scheduler_if.sv
// rtl/elevator_request_scheduler_if.sv - keypad/controller-side signal bundle for the elevator request scheduler
interface elevator_request_scheduler_if;
    logic [3:0] floor_key;
    logic [1:0] cur_floor;
    logic       target_ack;
    logic       arrived;
    logic [1:0] target_floor;
    logic       target_valid;
    logic [3:0] pending;
    logic       dir_up;
    logic       sched_idle;

    modport master (
        output floor_key, cur_floor, target_ack, arrived,
        input  target_floor, target_valid, pending, dir_up, sched_idle
    );

    modport slave (
        input  floor_key, cur_floor, target_ack, arrived,
        output target_floor, target_valid, pending, dir_up, sched_idle
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - SCAN floor-call scheduler with valid/ack target handoff
// Optional idle home-return trip enabled by defining HOME_RETURN_EN.
module elevator_request_scheduler #(
    parameter int HOME_FLOOR = 0,
    parameter int HOME_DELAY = 255
) (
    input  logic clk,
    input  logic reset,
    elevator_request_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, SERVE} state_t;

    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic       dir_q, dir_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] clr_mask, up_mask, dn_mask;
    logic       sel_found, sel_flip;
    logic [1:0] sel_floor;
    logic       valid_c, idle_c;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) lowest_set = 2'(i);
    endfunction

    function automatic logic [1:0] highest_set(input logic [3:0] m);
        highest_set = 2'd0;
        for (int i = 0; i < 4; i++) if (m[i]) highest_set = 2'(i);
    endfunction

    // Clearing on arrival beats a simultaneous key press for the same floor.
    assign clr_mask  = bus.arrived ? (4'b0001 << bus.cur_floor) : 4'b0000;
    assign pending_d = (pending_q | bus.floor_key) & ~clr_mask;

    assign up_mask = pending_q & (4'b1110 << bus.cur_floor);
    assign dn_mask = pending_q & ((4'b0001 << bus.cur_floor) - 4'b0001);

    always_comb begin
        sel_found = 1'b1;
        sel_flip  = 1'b0;
        sel_floor = bus.cur_floor;
        if (pending_q[bus.cur_floor]) begin
            sel_floor = bus.cur_floor;
        end else if (dir_q && (up_mask != 4'b0000)) begin
            sel_floor = lowest_set(up_mask);
        end else if (!dir_q && (dn_mask != 4'b0000)) begin
            sel_floor = highest_set(dn_mask);
        end else if (dir_q && (dn_mask != 4'b0000)) begin
            sel_floor = highest_set(dn_mask);
            sel_flip  = 1'b1;
        end else if (!dir_q && (up_mask != 4'b0000)) begin
            sel_floor = lowest_set(up_mask);
            sel_flip  = 1'b1;
        end else begin
            sel_found = 1'b0;
        end
    end

`ifdef HOME_RETURN_EN
    localparam logic [1:0] HOME    = 2'(HOME_FLOOR);
    localparam logic [7:0] HOME_DLY = 8'(HOME_DELAY);

    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       cnt_cond, home_go;

    assign cnt_cond   = (state_q == IDLE) && (pending_q == 4'b0000) && (bus.cur_floor != HOME);
    assign home_go    = cnt_cond && (idle_cnt_q == HOME_DLY);
    assign idle_cnt_d = cnt_cond ? idle_cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_cnt_q <= 8'd0;
        else       idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_home;
    assign unused_home = ^{HOME_FLOOR, HOME_DELAY};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    state_d = SELECT;
                end
`ifdef HOME_RETURN_EN
                else if (home_go) begin
                    state_d  = ISSUE;
                    target_d = HOME;
                    dir_d    = (HOME > bus.cur_floor);
                end
`endif
            end
            SELECT: begin
                if (sel_found) begin
                    state_d  = ISSUE;
                    target_d = sel_floor;
                    if (sel_flip) dir_d = ~dir_q;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   if (bus.target_ack) state_d = SERVE;
            SERVE: begin
                if (bus.arrived && (bus.cur_floor == target_q))
                    state_d = (pending_d != 4'b0000) ? SELECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_c = (state_q == ISSUE);
        idle_c  = (state_q == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q  <= 2'd0;
            dir_q     <= 1'b1;
            pending_q <= 4'b0000;
        end else begin
            target_q  <= target_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    assign bus.target_floor = target_q;
    assign bus.target_valid = valid_c;
    assign bus.pending      = pending_q;
    assign bus.dir_up       = dir_q;
    assign bus.sched_idle   = idle_c;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - directed-vector bench for elevator_request_scheduler
module tb_elevator_request_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    elevator_request_scheduler_if bus();

    elevator_request_scheduler #(.HOME_FLOOR(0), .HOME_DELAY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        bus.floor_key  = 4'b0000;
        bus.cur_floor  = 2'd0;
        bus.target_ack = 1'b0;
        bus.arrived    = 1'b0;
        tick();
        check("rst_valid", bus.target_valid, 0);
        check("rst_tgt",   bus.target_floor, 0);
        check("rst_pend",  bus.pending, 0);
        check("rst_dir",   bus.dir_up, 1);
        check("rst_idle",  bus.sched_idle, 1);
        reset = 1'b0;

        // single call at floor 2 from floor 0
        bus.floor_key = 4'b0100;
        tick(); bus.floor_key = 4'b0000;
        check("a_pend",  bus.pending, 4'b0100);
        check("a_idle",  bus.sched_idle, 1);
        check("a_v1",    bus.target_valid, 0);
        tick();
        check("a_v2",    bus.target_valid, 0);
        check("a_sel",   bus.sched_idle, 0);
        tick();
        check("a_valid", bus.target_valid, 1);
        check("a_tgt",   bus.target_floor, 2);
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        check("a_drop",  bus.target_valid, 0);
        bus.cur_floor = 2'd2; bus.arrived = 1'b1;
        tick(); bus.arrived = 1'b0;
        check("a_clr",   bus.pending, 0);
        check("a_done",  bus.sched_idle, 1);
        check("a_dir",   bus.dir_up, 1);

        // set and clear of the same floor in one cycle
        bus.floor_key = 4'b0100; bus.arrived = 1'b1;
        tick(); bus.floor_key = 4'b0000; bus.arrived = 1'b0;
        check("sc_pend", bus.pending, 0);
        tick();
        check("sc_idle", bus.sched_idle, 1);

        // SCAN: from floor 1 going up with calls at 0 and 3
        bus.cur_floor = 2'd1; bus.floor_key = 4'b1001;
        tick(); bus.floor_key = 4'b0000;
        check("s_pend",  bus.pending, 4'b1001);
        tick(); tick();
        check("s_tgt1",  bus.target_floor, 3);
        check("s_v1",    bus.target_valid, 1);
        check("s_dir1",  bus.dir_up, 1);
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        bus.cur_floor = 2'd3; bus.arrived = 1'b1;
        tick(); bus.arrived = 1'b0;
        check("s_pend2", bus.pending, 4'b0001);
        check("s_v2a",   bus.target_valid, 0);
        tick();
        check("s_tgt2",  bus.target_floor, 0);
        check("s_v2",    bus.target_valid, 1);
        check("s_dir2",  bus.dir_up, 0);
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        bus.cur_floor = 2'd0; bus.arrived = 1'b1;
        tick(); bus.arrived = 1'b0;
        check("s_idle",  bus.sched_idle, 1);
        check("s_pend3", bus.pending, 0);

        // held target while ack stays low; a new call only latches
        bus.floor_key = 4'b0010;
        tick(); bus.floor_key = 4'b0000;
        tick(); tick();
        check("h_tgt",   bus.target_floor, 1);
        check("h_dir",   bus.dir_up, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.floor_key = 4'b1000;
            tick(); bus.floor_key = 4'b0000;
            check("h_valid", bus.target_valid, 1);
            check("h_stab",  bus.target_floor, 1);
        end
        check("h_pend",  bus.pending, 4'b1010);

        // reset in the middle of a trip
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        check("r_srv_v", bus.target_valid, 0);
        check("r_srv_i", bus.sched_idle, 0);
        check("r_srv_p", bus.pending, 4'b1010);
        reset = 1'b1;
        #1;
        check("r_valid", bus.target_valid, 0);
        check("r_tgt",   bus.target_floor, 0);
        check("r_pend",  bus.pending, 0);
        check("r_dir",   bus.dir_up, 1);
        check("r_idle",  bus.sched_idle, 1);
        tick();
        reset = 1'b0; bus.cur_floor = 2'd2;

`ifdef HOME_RETURN_EN
        // key press at idle count 3 preempts the home trip
        tick(); tick(); tick();
        bus.floor_key = 4'b0100;
        tick(); bus.floor_key = 4'b0000;
        check("hk_idle", bus.sched_idle, 1);
        tick(); tick();
        check("hk_v",    bus.target_valid, 1);
        check("hk_tgt",  bus.target_floor, 2);
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        bus.arrived = 1'b1;
        tick(); bus.arrived = 1'b0;
        check("hk_done", bus.sched_idle, 1);
        // uninterrupted idle at floor 2 triggers the home trip
        tick(); tick(); tick(); tick();
        check("hm_v0",   bus.target_valid, 0);
        tick();
        check("hm_v",    bus.target_valid, 1);
        check("hm_tgt",  bus.target_floor, 0);
        check("hm_dir",  bus.dir_up, 0);
        bus.target_ack = 1'b1;
        tick(); bus.target_ack = 1'b0;
        bus.cur_floor = 2'd0; bus.arrived = 1'b1;
        tick(); bus.arrived = 1'b0;
        check("hm_idle", bus.sched_idle, 1);
`else
        repeat (8) tick();
        check("nh_idle", bus.sched_idle, 1);
        check("nh_v",    bus.target_valid, 0);
        check("nh_tgt",  bus.target_floor, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Latches floor-call keys for the 4-floor car and picks the next target floor with a SCAN (keep-direction) policy. Hands the target to the car state-change/motion logic over a valid/ack handshake, then waits for the arrival indication before scheduling again. Sits between the floor keypad and the state-change controller, which gives it its floor target.

Parameters:
HOME_FLOOR, 0, floor the car returns to when idle (used only with HOME_RETURN_EN)
HOME_DELAY, 255, idle cycles before the home trip is issued (8-bit; used only with HOME_RETURN_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
floor_key  input  4  call keys, bit i = floor i, level-sensitive
cur_floor  input  2  current car floor (the u1..u0 encoding)
target_ack  input  1  controller accepted target_floor
arrived  input  1  one-cycle pulse: car stopped at cur_floor, door opening
target_floor  output  2  selected destination
target_valid  output  1  target_floor valid, held until target_ack
pending  output  4  latched outstanding calls
dir_up  output  1  1 = sweeping up, 0 = sweeping down
sched_idle  output  1  1 when FSM is in IDLE

Behaviour:
- Reset (async, active-high): state IDLE, target_floor=0, target_valid=0, pending=0, dir_up=1, sched_idle=1, idle counter=0.
- pending[i] next = (pending[i] | floor_key[i]) & ~(arrived & cur_floor==i). The clear wins on the same cycle as a set for the same floor.
- FSM states: IDLE, SELECT, ISSUE, SERVE.
- IDLE: sched_idle=1. If pending!=0, go to SELECT next cycle.
- SELECT (1 cycle) decides in this priority order:
  1. pending[cur_floor] set: target = cur_floor, dir unchanged.
  2. Otherwise, the nearest pending floor in the dir_up direction.
  3. Otherwise, the nearest pending floor in the opposite direction, and dir_up toggles.
  - target_floor is registered. Go to ISSUE.
- ISSUE: target_valid=1, target_floor stable. On target_ack=1, target_valid drops the next cycle and the FSM goes to SERVE. No timeout.
- SERVE: waits for arrived.
  - arrived with cur_floor==target_floor: go to SELECT if the post-clear pending!=0, else IDLE.
  - arrived at a different floor: clears that floor's pending bit and stays in SERVE.
- No re-targeting: calls arriving during ISSUE/SERVE only latch into pending.
- target_ack outside ISSUE is ignored. arrived outside SERVE only clears pending.
- Latency:
  - Key to target_valid from IDLE is 3 cycles: latch, SELECT, ISSUE.
  - Arrival to the next target_valid is 2 cycles.
- Reset asserted mid-operation aborts any trip immediately. Pending calls are lost.

Optional Feature:
HOME_RETURN_EN
- Defined:
  - An 8-bit idle counter increments each cycle while in IDLE with pending==0 and cur_floor!=HOME_FLOOR. Any other condition clears it.
  - When the count reaches HOME_DELAY, the FSM goes directly to ISSUE with target_floor=HOME_FLOOR, and dir_up is set toward HOME_FLOOR. SERVE completion is as normal.
  - A call latched during the home trip is served after arrival.
- Undefined: no counter. The FSM stays in IDLE with target_floor holding its last value, and both parameters are unused.

Test Plan:
- Reset mid-SERVE with pending=1010 -> all outputs return to reset values the same cycle, and pending=0000.
- cur_floor=0, pulse floor_key=0100 -> target_valid=1 with target_floor=2 at cycle 3. Ack the target, pulse arrived with cur_floor=2 -> pending=0000 and the FSM returns to IDLE.
- SCAN order:
  - Setup: cur_floor=1, dir_up=1, pending=1001.
  - Expect target=3 first. After arrival at 3, expect target=0 with dir_up=0.
- Simultaneous set and clear: floor_key[2]=1 on the same cycle as arrived with cur_floor=2 -> pending[2]=0.
- Hold target_ack=0 for 10 cycles -> target_valid stays 1 and target_floor stays stable. Press key 3 during this time -> target is unchanged and pending[3]=1.
- HOME_RETURN_EN with HOME_DELAY=4, idle at floor 2 -> target_valid=1 with target_floor=0 after 4 idle cycles plus 1. A key press at count 3 -> counter clears and no home trip is issued.
